mem_bus_controller: RTL and testbench
=====================================

Name: mem_bus_controller

Overview:
- Sits directly downstream of the data-cache controller.
- Turns one line-granular request (write-back of a dirty victim, or fill of a missing line) into a timed word-by-word sequence on the single-word main-memory port.
- Returns a one-cycle completion pulse plus the assembled fill line.
- The cache controller holds the PC and waits for the completion pulse, replacing its fixed wait states.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width; fixed at 32, with byte-addressed words of 4 bytes.
- WORDS_PER_LINE, 4, words per cache line; must be a power of 2 and at least 1.
- LATENCY, 4, wait cycles before the first beat; 0 is legal.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; a request is accepted when req_valid and req_ready are both high at a rising edge.
- req_write  in  1  1 = write-back line, 0 = fill line.
- req_addr  in  ADDR_W  any byte address inside the target line.
- req_wdata  in  DATA_W*WORDS_PER_LINE  line to write; word k occupies bits [32k+31:32k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W*WORDS_PER_LINE  fill line, same word packing as req_wdata.
- mem_addr  out  ADDR_W  word address presented to memory, byte address with low 2 bits = 0.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  word to write.
- mem_rdata  in  DATA_W  combinational read data for mem_addr, valid in the same cycle.

Behaviour:
- Reset is synchronous and active-high; it is decided for this block and not changeable.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, mem_addr=0, mem_we=0, mem_wdata=0, state=IDLE, all counters 0.
- FSM states are IDLE, WAIT, XFER, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch the line base = req_addr with the low log2(4*WORDS_PER_LINE) bits cleared.
  - Latch req_write and req_wdata.
  - Go to WAIT, or to XFER if LATENCY=0.
  - req_valid while req_ready=0 is ignored; there is no queueing, and the requester holds its request.
- WAIT: the counter counts LATENCY cycles; mem_we=0; then go to XFER with beat=0.
- XFER: runs WORDS_PER_LINE cycles, beat = 0 to WORDS_PER_LINE-1.
  - mem_addr = base + 4*beat, computed modulo 2^ADDR_W; wrap-around is allowed.
  - Write request: mem_we=1 and mem_wdata = latched word[beat].
  - Read request: mem_we=0, and mem_rdata is captured into line-buffer word[beat] at the clock edge.
  - After the last beat, go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata = line buffer; it holds its value until the next fill completes, and write requests leave it unchanged.
  - Next state is IDLE.
- Timing, with the accept edge at the end of cycle 0:
  - WAIT occupies cycles 1 to LATENCY.
  - XFER occupies cycles LATENCY+1 to LATENCY+WORDS_PER_LINE.
  - resp_valid is high in cycle LATENCY+WORDS_PER_LINE+1; the default is cycle 9.
  - req_ready returns to 1 in the following cycle, so the minimum request spacing is LATENCY+WORDS_PER_LINE+2 cycles.
- Outside XFER: mem_we=0 and mem_addr holds its last value.
- Back-to-back write-back then fill: the second request can be accepted no earlier than the cycle after DONE.
- Reset mid-operation:
  - Aborts at that edge; mem_we is 0 from the next cycle.
  - No resp_valid is produced; any partial line-buffer contents are cleared to 0.
- req_write and req_addr changing after accept have no effect.

Optional Feature:
- Macro: MEM_BUS_STATS_EN.
- When defined, two extra output ports are added:
  - rd_lines  out  16  count of completed fills.
  - wr_lines  out  16  count of completed write-backs.
- Each counter increments in the DONE cycle, saturates at 16'hFFFF, and is cleared to 0 by reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum (IDLE, WAIT, XFER, DONE);
  - WORD_BYTES=4;
  - a function deriving the line offset bit count from WORDS_PER_LINE.
- There is no sub-module: the counters and line buffer are small enough to stay flat in one module.

Test Plan:
1. Fill, default parameters: memory words at 0x100..0x10C hold 0x11,0x22,0x33,0x44; request req_addr=0x108 with req_write=0.
   - mem_addr steps 0x100,0x104,0x108,0x10C in cycles 5–8.
   - resp_valid is high in cycle 9 only.
   - resp_rdata = {0x44,0x33,0x22,0x11}.
2. Write-back: req_addr=0x200 with req_wdata={0xD,0xC,0xB,0xA}.
   - mem_we=1 in cycles 5–8 only, writing 0xA..0xD to 0x200..0x20C.
   - resp_rdata is unchanged from the previous fill.
3. Handshake: hold req_valid high continuously.
   - Accepts occur at cycle 0 and cycle 10, never in between.
   - req_ready=0 in cycles 1–9.
4. Wrap-around: req_addr=0xFFFFFFF4 on a fill.
   - mem_addr sequence is 0xFFFFFFF0, 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC.
5. Reset in cycle 6 of a write-back:
   - mem_we=0 from cycle 7 onward.
   - No resp_valid.
   - req_ready=1 after reset is released.
6. LATENCY=0 with MEM_BUS_STATS_EN defined: run a fill then a write-back.
   - resp_valid is in cycle 5 of each request.
   - After both, rd_lines=1 and wr_lines=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the line-to-word memory bus controller: state
// encoding, word size and line offset derivation.
package mem_bus_pkg;

   localparam int WORD_BYTES = 4;

   // state    | meaning
   // ST_IDLE  | ready for a new line request
   // ST_WAIT  | memory latency countdown before the first beat
   // ST_XFER  | one word per cycle, beat 0 .. WORDS_PER_LINE-1
   // ST_DONE  | one-cycle completion pulse
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_XFER = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Number of byte-address bits covered by one cache line.
   function automatic int line_off_bits(input int words_per_line);
      return $clog2(words_per_line * WORD_BYTES);
   endfunction

endpackage

// File: rtl/mem_bus_controller.sv
// Line-granular request to word-by-word main-memory sequencer.
// Optional line counters are enabled with the macro MEM_BUS_STATS_EN.
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for req_valid
// ST_WAIT  | down-counting LATENCY cycles, mem_we low
// ST_XFER  | driving mem_addr = base + 4*beat, write or capture a word
// ST_DONE  | resp_valid pulse, resp_rdata holds the last completed fill
module mem_bus_controller
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int LATENCY        = 4
)(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_W-1:0]                req_addr,
   input  logic [DATA_W*WORDS_PER_LINE-1:0] req_wdata,
   output logic                             resp_valid,
   output logic [DATA_W*WORDS_PER_LINE-1:0] resp_rdata,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic                             mem_we,
   output logic [DATA_W-1:0]                mem_wdata,
   input  logic [DATA_W-1:0]                mem_rdata
`ifdef MEM_BUS_STATS_EN
   ,
   output logic [15:0]                      rd_lines,
   output logic [15:0]                      wr_lines
`endif
);

   localparam int LINE_W   = DATA_W * WORDS_PER_LINE;
   localparam int OFF_BITS = line_off_bits(WORDS_PER_LINE);
   localparam int BEAT_W   = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
   localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_BITS) - ADDR_W'(1));
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_t              state;
   logic                wr_q;
   logic                accept;
   logic [ADDR_W-1:0]   base_q;
   logic [BEAT_W-1:0]   beat;
   logic [CNT_W-1:0]    wait_cnt;
   // Holds the write-back data, or the fill being assembled; resp_rdata is
   // only updated once a fill completes so it stays stable meanwhile.
   logic [LINE_W-1:0]   line_buf;
   logic [LINE_W-1:0]   line_next;

   assign accept     = req_valid & req_ready;
   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_DONE);
   assign mem_we     = (state == ST_XFER) & wr_q;
   assign mem_wdata  = mem_we ? line_buf[beat*DATA_W +: DATA_W] : '0;

   // Line buffer with the current beat's read word merged in.
   always_comb begin
      line_next = line_buf;
      line_next[beat*DATA_W +: DATA_W] = mem_rdata;
   end

   // Request FSM, latency timer, beat counter and line assembly.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         wr_q       <= 1'b0;
         base_q     <= '0;
         beat       <= '0;
         wait_cnt   <= '0;
         line_buf   <= '0;
         resp_rdata <= '0;
         mem_addr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  base_q   <= req_addr & BASE_MASK;
                  wr_q     <= req_write;
                  line_buf <= req_wdata;
                  beat     <= '0;
                  wait_cnt <= WAIT_LOAD;
                  if (LATENCY == 0) begin
                     state    <= ST_XFER;
                     mem_addr <= req_addr & BASE_MASK;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  state    <= ST_XFER;
                  mem_addr <= base_q;
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            ST_XFER: begin
               if (!wr_q) begin
                  line_buf <= line_next;
               end
               if (beat == LAST_BEAT) begin
                  state <= ST_DONE;
                  if (!wr_q) begin
                     resp_rdata <= line_next;
                  end
               end else begin
                  beat     <= beat + BEAT_W'(1);
                  mem_addr <= mem_addr + ADDR_W'(WORD_BYTES);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MEM_BUS_STATS_EN
   // Saturating completed-line counters, bumped in the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_lines <= '0;
         wr_lines <= '0;
      end else if (state == ST_DONE) begin
         if (wr_q) begin
            if (wr_lines != 16'hFFFF) wr_lines <= wr_lines + 16'd1;
         end else begin
            if (rd_lines != 16'hFFFF) rd_lines <= rd_lines + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller: one default-latency instance and
// one LATENCY=0 instance; line counters checked when MEM_BUS_STATS_EN is set.
module tb_mem_bus_controller;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid, req_valid0;
   logic         req_write;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;

   logic         req_ready, resp_valid, mem_we;
   logic [127:0] resp_rdata;
   logic [31:0]  mem_addr, mem_wdata, mem_rdata;

   logic         req_ready0, resp_valid0, mem_we0;
   logic [127:0] resp_rdata0;
   logic [31:0]  mem_addr0, mem_wdata0, mem_rdata0;

`ifdef MEM_BUS_STATS_EN
   logic [15:0]  rd_lines, wr_lines, rd_lines0, wr_lines0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h100: return 32'h11;
         32'h104: return 32'h22;
         32'h108: return 32'h33;
         32'h10C: return 32'h44;
         default: return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   assign mem_rdata  = mem_model(mem_addr);
   assign mem_rdata0 = mem_model(mem_addr0);

   mem_bus_controller dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef MEM_BUS_STATS_EN
      , .rd_lines(rd_lines), .wr_lines(wr_lines)
`endif
   );

   mem_bus_controller #(.LATENCY(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
      .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0)
`ifdef MEM_BUS_STATS_EN
      , .rd_lines(rd_lines0), .wr_lines(wr_lines0)
`endif
   );

   int checks = 0;
   int passes = 0;

   logic [11:0] obs_we, obs_rv, obs_rdy, obs_acc;
   logic [31:0] obs_addr  [12];
   logic [31:0] obs_wdata [12];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One request starting at the current negedge (cycle 0); records cycles 0..11.
   task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                         input logic [127:0] wd, input bit hold, input int rst_cyc);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 0) begin
            req_write = wr;
            req_addr  = addr;
            req_wdata = wd;
            if (sel == 0) req_valid = 1'b1; else req_valid0 = 1'b1;
         end else if (c == 1 && !hold) begin
            req_valid  = 1'b0;
            req_valid0 = 1'b0;
            req_write  = ~wr;
            req_addr   = ~addr;
            req_wdata  = ~wd;
         end
         if (c == rst_cyc) reset = 1'b1;
         if (c == rst_cyc + 1) reset = 1'b0;
         if (sel == 0) begin
            obs_we[c]    = mem_we;
            obs_rv[c]    = resp_valid;
            obs_rdy[c]   = req_ready;
            obs_acc[c]   = req_valid & req_ready;
            obs_addr[c]  = mem_addr;
            obs_wdata[c] = mem_wdata;
         end else begin
            obs_we[c]    = mem_we0;
            obs_rv[c]    = resp_valid0;
            obs_rdy[c]   = req_ready0;
            obs_acc[c]   = req_valid0 & req_ready0;
            obs_addr[c]  = mem_addr0;
            obs_wdata[c] = mem_wdata0;
         end
      end
      req_valid  = 1'b0;
      req_valid0 = 1'b0;
   endtask

   localparam logic [127:0] FILL1 = {32'h44, 32'h33, 32'h22, 32'h11};
   localparam logic [127:0] WB    = {32'hD, 32'hC, 32'hB, 32'hA};

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_valid0 = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      repeat (3) @(negedge clk);

      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset = 1'b0;
      @(negedge clk);

      // Fill of the line containing 0x108.
      do_req(0, 1'b0, 32'h108, '0, 1'b0, -1);
      for (int c = 5; c <= 8; c++)
         chk($sformatf("t1_addr_c%0d", c), obs_addr[c], 32'h100 + 4 * (c - 5));
      chk("t1_we_vec", obs_we, 12'h000);
      chk("t1_rv_vec", obs_rv, 12'h200);
      chk("t1_rdy_vec", obs_rdy, 12'hC01);
      chk("t1_rdata", resp_rdata, FILL1);

      // Write-back of line 0x200.
      do_req(0, 1'b1, 32'h200, WB, 1'b0, -1);
      chk("t2_we_vec", obs_we, 12'h1E0);
      chk("t2_rv_vec", obs_rv, 12'h200);
      for (int c = 5; c <= 8; c++) begin
         chk($sformatf("t2_addr_c%0d", c), obs_addr[c], 32'h200 + 4 * (c - 5));
         chk($sformatf("t2_wdata_c%0d", c), obs_wdata[c], 32'hA + (c - 5));
      end
      chk("t2_rdata_kept", resp_rdata, FILL1);

      // req_valid held high: accepts only at cycles 0 and 10.
      do_req(0, 1'b1, 32'h300, WB, 1'b1, -1);
      chk("t3_acc_vec", obs_acc, 12'h401);
      chk("t3_rdy_vec", obs_rdy, 12'h401);
      repeat (12) @(negedge clk);
      chk("t3_idle_after", req_ready, 1);

      // Fill wrapping the top of the address space.
      do_req(0, 1'b0, 32'hFFFF_FFF4, '0, 1'b0, -1);
      for (int c = 5; c <= 8; c++)
         chk($sformatf("t4_addr_c%0d", c), obs_addr[c], 32'hFFFF_FFF0 + 4 * (c - 5));
      chk("t4_rdata", resp_rdata, {32'hFFFF_FFFC ^ 32'h5A5A_0000, 32'hFFFF_FFF8 ^ 32'h5A5A_0000,
                                   32'hFFFF_FFF4 ^ 32'h5A5A_0000, 32'hFFFF_FFF0 ^ 32'h5A5A_0000});

      // Reset taken at the end of cycle 6 of a write-back.
      do_req(0, 1'b1, 32'h400, WB, 1'b0, 6);
      chk("t5_we_vec", obs_we, 12'h060);
      chk("t5_rv_vec", obs_rv, 12'h000);
      chk("t5_rdy_vec", obs_rdy, 12'hF81);
      chk("t5_mem_addr", mem_addr, 0);
      chk("t5_rdata_cleared", resp_rdata, 0);

      // LATENCY=0 instance: fill then write-back.
      do_req(1, 1'b0, 32'h104, '0, 1'b0, -1);
      chk("t6_fill_rv_vec", obs_rv, 12'h020);
      chk("t6_fill_addr_c1", obs_addr[1], 32'h100);
      chk("t6_fill_addr_c4", obs_addr[4], 32'h10C);
      chk("t6_fill_rdata", resp_rdata0, FILL1);
      do_req(1, 1'b1, 32'h20C, WB, 1'b0, -1);
      chk("t6_wb_rv_vec", obs_rv, 12'h020);
      chk("t6_wb_we_vec", obs_we, 12'h01E);
      chk("t6_wb_wdata_c4", obs_wdata[4], 32'hD);
      chk("t6_wb_rdata_kept", resp_rdata0, FILL1);
`ifdef MEM_BUS_STATS_EN
      chk("t6_rd_lines", rd_lines0, 1);
      chk("t6_wr_lines", wr_lines0, 1);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
